// File: rtl/csr_pkg.sv
// Shared definitions for the AXI4-Lite CSR slave: register indices,
// bit positions, response codes, channel state types and a strobe helper.
package csr_pkg;

  localparam int CSR_CTRL_IDX   = 0;
  localparam int CSR_STATUS_IDX = 1;
  localparam int START_BIT      = 0;
  localparam int DONE_BIT       = 0;
  localparam int BUSY_BIT       = 1;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axil_wr_ch_merge.sv
// Joins the independent AW and W channels into one write strobe and runs
// the B-channel response. Address and data may arrive in either order or
// together; the write fires in the cycle the second of them is accepted.
module axil_wr_ch_merge
  import csr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb
);

  wr_state_t         state_reg, state_next;
  logic              ready_en_reg;
  logic              aw_held_reg, w_held_reg;
  logic [ADDR_W-1:0] awaddr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              aw_hs, w_hs;

  // State register; ready_en_reg keeps the READY outputs low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= W_IDLE;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Next state: leave idle on the write strobe, return on B handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      W_IDLE:  if (wr_en) state_next = W_RESP;
      W_RESP:  if (bready) state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  // Outputs: each channel is ready until its beat is latched.
  always_comb begin
    awready = ready_en_reg && (state_reg == W_IDLE) && !aw_held_reg;
    wready  = ready_en_reg && (state_reg == W_IDLE) && !w_held_reg;
    bvalid  = (state_reg == W_RESP);
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    wr_en   = (state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
  end

  // Channel latches: capture each beat on its handshake, clear on B handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else if (state_reg == W_RESP && bready) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        awaddr_reg  <= awaddr;
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= wdata;
        wstrb_reg  <= wstrb;
      end
    end
  end

  // The beat arriving in the strobe cycle bypasses its latch.
  assign wr_addr = aw_held_reg ? awaddr_reg : awaddr;
  assign wr_data = w_held_reg ? wdata_reg : wdata;
  assign wr_strb = w_held_reg ? wstrb_reg : wstrb;

endmodule

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite CSR slave: register file, CTRL start pulse, sticky STATUS done.
// Optional macro CSR_WSTRB_EN enables per-byte write strobes; without it
// WSTRB is ignored and every write updates all four bytes.
module axi_lite_csr_slave
  import csr_pkg::*;
#(
  parameter int          CSR_REG_NUM = 64,
  parameter int          ADDR_W      = $clog2(CSR_REG_NUM) + 2,
  parameter logic [31:0] RST_VAL     = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic                     start_o,
  input  logic                     done_i,
  input  logic                     busy_i,
  output logic [32*CSR_REG_NUM-1:0] csr_o
);

  localparam int IDX_W = $clog2(CSR_REG_NUM);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_idx32, rd_idx32;
  logic              wr_hit, rd_in_range;
  logic [31:0]       wr_mask;
  logic              strb0_ok;
  logic [31:0]       word_view [CSR_REG_NUM];
  logic [31:0]       status_word;
  logic              done_reg, start_reg;
  rd_state_t         rd_state_reg, rd_state_next;
  logic              rd_en_reg;
  logic [31:0]       rdata_reg;
  logic              unused_ok;

  axil_wr_ch_merge #(.ADDR_W(ADDR_W)) u_wr_merge (
    .clk     (clk),
    .rst_n   (rst_n),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .awaddr  (S_AXI_AWADDR),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  assign S_AXI_BRESP = OKAY;
  assign S_AXI_RRESP = OKAY;

  // Word index widened to 32 bits so an oversized ADDR_W can be range-checked.
  assign wr_idx32    = 32'(wr_addr[ADDR_W-1:2]);
  assign rd_idx32    = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
  assign wr_hit      = wr_en && (wr_idx32 < CSR_REG_NUM);
  assign rd_in_range = rd_idx32 < CSR_REG_NUM;

`ifdef CSR_WSTRB_EN
  assign wr_mask  = strb_to_mask(wr_strb);
  assign strb0_ok = wr_strb[0];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};
`else
  assign wr_mask  = '1;
  assign strb0_ok = 1'b1;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0], wr_strb};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CSR_REG_NUM; gi++) begin : g_word
      if (gi == CSR_STATUS_IDX) begin : g_status
        assign word_view[gi] = status_word;
      end else begin : g_rw
        // CTRL bit0 is a pulse trigger and is never stored.
        localparam logic [31:0] FIXED0 = (gi == CSR_CTRL_IDX) ? 32'h1 : 32'h0;
        logic [31:0] word_reg;
        // Plain R/W word with byte-masked update.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_reg <= RST_VAL & ~FIXED0;
          end else if (wr_hit && wr_idx32 == 32'(gi)) begin
            word_reg <= ((word_reg & ~wr_mask) | (wr_data & wr_mask)) & ~FIXED0;
          end
        end
        assign word_view[gi] = word_reg;
      end
      assign csr_o[32*gi +: 32] = word_view[gi];
    end
  endgenerate

  // STATUS is assembled live: sticky done plus the engine busy level.
  always_comb begin
    status_word           = '0;
    status_word[DONE_BIT] = done_reg;
    status_word[BUSY_BIT] = busy_i;
  end

  // Sticky done: an engine pulse takes priority over a same-cycle CPU clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else if (done_i) begin
      done_reg <= 1'b1;
    end else if (wr_hit && wr_idx32 == CSR_STATUS_IDX && wr_data[DONE_BIT] && strb0_ok) begin
      done_reg <= 1'b0;
    end
  end

  // Start pulse appears the cycle after a write of 1 to CTRL bit0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg <= 1'b0;
    end else begin
      start_reg <= wr_hit && wr_idx32 == CSR_CTRL_IDX && wr_data[START_BIT] && strb0_ok;
    end
  end
  assign start_o = start_reg;

  // Read state register; rd_en_reg keeps ARREADY low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= R_IDLE;
      rd_en_reg    <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_en_reg    <= 1'b1;
    end
  end

  // Read next state: address accepted -> hold data until the master takes it.
  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (S_AXI_ARVALID && S_AXI_ARREADY) rd_state_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Read channel handshake outputs.
  always_comb begin
    S_AXI_ARREADY = rd_en_reg && (rd_state_reg == R_IDLE);
    S_AXI_RVALID  = (rd_state_reg == R_DATA);
  end

  // Read data captured at the AR handshake, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rdata_reg <= rd_in_range ? word_view[rd_idx32[IDX_W-1:0]] : 32'h0;
    end
  end
  assign S_AXI_RDATA = rdata_reg;

endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Directed bench for axi_lite_csr_slave (default 64 words, 8-bit address).
module tb_axi_lite_csr_slave;

  localparam int N  = 64;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            S_AXI_AWVALID, S_AXI_AWREADY;
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT, S_AXI_ARPROT;
  logic [31:0]     S_AXI_WDATA;
  logic [3:0]      S_AXI_WSTRB;
  logic            S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP, S_AXI_RRESP;
  logic            S_AXI_BVALID, S_AXI_BREADY;
  logic            S_AXI_ARVALID, S_AXI_ARREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [31:0]     S_AXI_RDATA;
  logic            S_AXI_RVALID, S_AXI_RREADY;
  logic            start_o, done_i, busy_i;
  logic [32*N-1:0] csr_o;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_csr_slave #(.CSR_REG_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .start_o(start_o), .done_i(done_i), .busy_i(busy_i), .csr_o(csr_o)
  );

  // Count every cycle in which start_o is high.
  always @(negedge clk) if (start_o === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full write transaction; optionally pulses done_i in the handshake cycle.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic pulse_done, input string tag);
    int n;
    logic aw_hs, w_hs, aw_pend, w_pend;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; done_i = pulse_done;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 50) begin
      @(negedge clk);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk); #1;
      done_i = 1'b0;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_hs) begin S_AXI_WVALID = 1'b0; w_pend = 1'b0; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; done_i = 1'b0;
    check({tag, "_accept"}, 32'(aw_pend || w_pend), 32'h0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (S_AXI_BVALID === 1'b1) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_bvalid"}, 32'(n < 50), 32'h1);
    check({tag, "_bresp"}, 32'(S_AXI_BRESP), 32'h0);
    @(posedge clk); #1;
    $display("write %s addr=0x%02h data=0x%08h strb=%b", tag, addr, data, strb);
  endtask

  // Full read transaction; also checks RVALID arrives one cycle after AR.
  task automatic axi_read(input logic [7:0] addr, input string tag, output logic [31:0] data);
    int n;
    logic ar_hs;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    ar_hs = 1'b0; n = 0;
    while (!ar_hs && n < 50) begin
      @(negedge clk);
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge clk); #1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    check({tag, "_araccept"}, 32'(ar_hs), 32'h1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (S_AXI_RVALID === 1'b1) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_rlatency"}, 32'(n), 32'h0);
    check({tag, "_rresp"}, 32'(S_AXI_RRESP), 32'h0);
    data = S_AXI_RDATA;
    @(posedge clk); #1;
    $display("read  %s addr=0x%02h data=0x%08h", tag, addr, data);
  endtask

  initial begin
    logic [31:0] rd;
    int s0, bcnt, stable;

    S_AXI_AWVALID = 0; S_AXI_AWADDR = 0; S_AXI_AWPROT = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    S_AXI_ARVALID = 0; S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_RREADY = 1;
    done_i = 0; busy_i = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'h0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_start", 32'(start_o), 32'h0);
    check("rst_csr_zero", 32'(csr_o == '0), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_awready", 32'(S_AXI_AWREADY), 32'h1);
    check("idle_arready", 32'(S_AXI_ARREADY), 32'h1);

    // Basic write / readback
    axi_write(8'h08, 32'hDEADBEEF, 4'hF, 1'b0, "w08");
    axi_read(8'h08, "r08", rd);
    check("r08_data", rd, 32'hDEADBEEF);
    check("csr_o_word2", csr_o[32*2 +: 32], 32'hDEADBEEF);
    axi_read(8'h20, "r20", rd);
    check("r20_unwritten", rd, 32'h0);

    // W arrives 3 cycles before AW
    S_AXI_WDATA = 32'h1234; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_WVALID = 1'b0;
    bcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (S_AXI_BVALID === 1'b1) bcnt++;
      @(posedge clk); #1;
    end
    check("wfirst_wready_low", 32'(S_AXI_WREADY), 32'h0);
    S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (S_AXI_BVALID === 1'b1) bcnt++;
      @(posedge clk); #1;
    end
    check("wfirst_bvalid_once", 32'(bcnt), 32'h1);
    $display("write wfirst addr=0x0c data=0x00001234 bvalid_cycles=%0d", bcnt);
    axi_read(8'h0C, "r0c", rd);
    check("r0c_data", rd, 32'h1234);
    check("csr_o_word3", csr_o[32*3 +: 32], 32'h1234);

    // Start pulse
    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'hF, 1'b0, "start");
    repeat (3) @(posedge clk); #1;
    check("start_pulse_cycles", 32'(start_cnt - s0), 32'h1);
    axi_read(8'h00, "r00", rd);
    check("ctrl_bit0_reads0", rd, 32'h0);
    s0 = start_cnt;
    axi_write(8'h00, 32'hF0000003, 4'hF, 1'b0, "ctrl_rw");
    repeat (3) @(posedge clk); #1;
    check("ctrl_rw_pulse", 32'(start_cnt - s0), 32'h1);
    axi_read(8'h00, "r00b", rd);
    check("ctrl_upper_rw", rd, 32'hF0000002);

    // Sticky done and busy
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    axi_read(8'h04, "st1", rd);
    check("status_done", rd, 32'h1);
    busy_i = 1'b1;
    axi_read(8'h04, "st2", rd);
    check("status_busy", rd, 32'h3);
    busy_i = 1'b0;
    axi_write(8'h04, 32'h1, 4'hF, 1'b1, "clr_vs_done");
    axi_read(8'h04, "st3", rd);
    check("done_set_wins", rd, 32'h1);
    axi_write(8'h04, 32'hFFFFFFFE, 4'hF, 1'b0, "noclr");
    axi_read(8'h04, "st4", rd);
    check("status_ro_bits", rd, 32'h1);
    axi_write(8'h04, 32'h1, 4'hF, 1'b0, "clr");
    axi_read(8'h04, "st5", rd);
    check("done_cleared", rd, 32'h0);

    // Back-pressure on B and R
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 8'h10; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 8'h08; S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (S_AXI_BVALID === 1'b1 && S_AXI_BRESP === 2'b00 && S_AXI_AWREADY === 1'b0 &&
          S_AXI_WREADY === 1'b0 && S_AXI_RVALID === 1'b1 && S_AXI_RDATA === 32'hDEADBEEF &&
          S_AXI_ARREADY === 1'b0) stable++;
      @(posedge clk); #1;
    end
    check("stall_stable_cycles", 32'(stable), 32'd10);
    $display("stall held_cycles=%0d", stable);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    check("stall_bvalid_drop", 32'(S_AXI_BVALID), 32'h0);
    check("stall_rvalid_drop", 32'(S_AXI_RVALID), 32'h0);
    check("stall_awready_back", 32'(S_AXI_AWREADY), 32'h1);
    check("stall_arready_back", 32'(S_AXI_ARREADY), 32'h1);
    axi_read(8'h10, "r10", rd);
    check("r10_data", rd, 32'hCAFEF00D);

    // Same-cycle read and write of one word
    S_AXI_AWADDR = 8'h14; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 8'h14;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("rw_coll_rvalid", 32'(S_AXI_RVALID), 32'h1);
    check("rw_coll_old_data", S_AXI_RDATA, 32'h0);
    check("rw_coll_bvalid", 32'(S_AXI_BVALID), 32'h1);
    @(posedge clk); #1;
    $display("collide addr=0x14 read_old=0x%08h", S_AXI_RDATA);
    axi_read(8'h14, "r14", rd);
    check("rw_coll_new_data", rd, 32'h55);

    // Byte strobes
    axi_write(8'h18, 32'hAABBCCDD, 4'b0010, 1'b0, "strb");
    axi_read(8'h18, "r18", rd);
`ifdef CSR_WSTRB_EN
    check("strb_lane1", rd, 32'h0000CC00);
`else
    check("strb_ignored", rd, 32'hAABBCCDD);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_csr_slave.md
Name: axi_lite_csr_slave

Overview:
AXI4-Lite responder that terminates the 32-bit CPU control bus in front of the accelerator's CSR space. It implements the slave side of the AW/W/B and AR/R handshakes and holds a register file of CSR_REG_NUM words. It also generates a one-cycle start pulse and a sticky done status for the compute engines (TRANSPOSE, conv, etc.). It sits between the CPU GP master port and the accelerator's control fabric.

Parameters:
CSR_REG_NUM, 64, number of 32-bit CSR words; power of two, minimum 4.
ADDR_W, $clog2(CSR_REG_NUM)+2, byte address width on S_AXI_*ADDR.
RST_VAL, 32'h0, reset value of every read/write register.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
S_AXI_AWVALID/AWREADY  in/out  1  write-address handshake
S_AXI_AWADDR  in  ADDR_W  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes (see Optional Feature)
S_AXI_WVALID/WREADY  in/out  1  write-data handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID/BREADY  out/in  1  write-response handshake
S_AXI_ARVALID/ARREADY  in/out  1  read-address handshake
S_AXI_ARADDR  in  ADDR_W  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID/RREADY  out/in  1  read-data handshake
start_o  out  1  one-cycle pulse on a write of 1 to reg0[0]
done_i  in  1  engine-done pulse
busy_i  in  1  live engine-busy level
csr_o  out  32*CSR_REG_NUM  flattened register file; word k at [32k+:32]

Behaviour:
- Reset: all READY/VALID outputs 0, RDATA 0, start_o 0, registers RST_VAL, status 0. Reset mid-transaction aborts the transaction; no response is issued.
- Word index = addr[ADDR_W-1:2]; addr[1:0] ignored.
- Write path, states W_IDLE/W_RESP:
  - AWREADY=1 while no address is latched and state is W_IDLE. WREADY=1 under the same condition for data.
  - AW and W are accepted independently, in either order or the same cycle, and each is latched.
  - When both are latched: the register updates in that cycle. BVALID rises the next cycle and the block enters W_RESP.
  - BVALID holds until BREADY. On BVALID&&BREADY the latches clear and the block returns to W_IDLE. This gives back-to-back write throughput of one per 2 cycles when BREADY is tied high.
- Read path, states R_IDLE/R_DATA:
  - ARREADY=1 in R_IDLE.
  - On ARVALID&&ARREADY, RDATA is registered and RVALID is set next cycle.
  - RDATA and RVALID stay stable until RREADY.
- Register map:
  - reg0 CTRL: bit0 is write-1-to-pulse start_o next cycle and always reads 0; bits[31:1] are R/W.
  - reg1 STATUS, read-only: bit0 sticky done, set by done_i, cleared by a CPU write with WDATA[0]=1; bit1 = busy_i. Writes never change any other STATUS bit.
  - reg2..N-1: plain R/W.
- Same-cycle collisions:
  - done_i set and CPU clear: set wins.
  - Read and write to the same word: read returns the old value.
- Out-of-range index (only possible if upper address bits are unused): write dropped, read returns 0, response still OKAY.

Optional Feature:
CSR_WSTRB_EN:
- Defined: each byte lane is written only when its WSTRB bit is 1. The start pulse and STATUS clear additionally require WSTRB[0]=1.
- Undefined: WSTRB is ignored and all 4 bytes are written.

Decomposition:
- Package csr_pkg: CSR_CTRL_IDX=0, CSR_STATUS_IDX=1, bit positions START_BIT=0, DONE_BIT=0, BUSY_BIT=1, typedef axil_resp_t (2-bit) with OKAY=2'b00.
- One natural sub-module: axil_wr_ch_merge, which latches and joins AW and W into a single write strobe.

Test Plan:
- Write 0xDEADBEEF to addr 0x08, then read 0x08 -> BRESP=0, RDATA=0xDEADBEEF, RVALID one cycle after the AR handshake.
- W presented 3 cycles before AW for a write of 0x1234 to addr 0x0C -> a single BVALID after AW arrives; readback 0x1234.
- Write 0x1 to addr 0x00 -> start_o high for exactly 1 cycle; a readback of reg0 returns 0x0.
- Pulse done_i, read 0x04 -> 0x1. Write 0x1 to 0x04 in the same cycle as a second done_i pulse -> the next read still returns 0x1.
- Hold BREADY and RREADY low for 10 cycles -> BVALID/RVALID and their data stay stable, and AWREADY/ARREADY stay 0.
- With CSR_WSTRB_EN defined, write WSTRB=4'b0010 and WDATA=0xAABBCCDD to a reg holding 0x0 -> readback 0x0000CC00.
